// File: rtl/systolic_feeder_pkg.sv
// Shared widths, address codes and the queued-word layout for the systolic tile feeder.
// SYSTOLIC_FEEDER_FIFO2_EN selects a two-entry FIFO per channel (default: single holding register).
package systolic_pkg;

    localparam int WORD_W  = 16;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = 4;

    localparam logic [1:0] ADDR_PASS = 2'd0;
    localparam logic [1:0] ADDR_AB   = 2'd1;
    localparam logic [1:0] ADDR_CLO  = 2'd2;
    localparam logic [1:0] ADDR_CHI  = 2'd3;

`ifdef SYSTOLIC_FEEDER_FIFO2_EN
    localparam int FIFO_DEPTH = 2;
`else
    localparam int FIFO_DEPTH = 1;
`endif

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [1:0]        addr;
        logic [1:0]        tag;
    } feeder_word_t;

    localparam feeder_word_t IDLE_WORD = '{data: '0, addr: ADDR_PASS, tag: 2'b00};

    // Nibble k of the frame, MSB nibble first.
    function automatic logic [NIB_W-1:0] word_nib(input feeder_word_t w, input logic [1:0] k);
        logic [WORD_W-1:0] s;
        s = w.data >> {~k, 2'b00};
        return s[NIB_W-1:0];
    endfunction

    // Control bit k of {addr, tag}, MSB first.
    function automatic logic word_ctrl(input feeder_word_t w, input logic [1:0] k);
        logic [3:0] c;
        c = {w.addr, w.tag};
        return c[~k];
    endfunction

endpackage

// File: rtl/systolic_feeder_fifo.sv
// Per-channel word FIFO (depth 1 or 2 from systolic_pkg); head is always entry 0.
// Caller only pushes when not full and only pops when not empty.
module feeder_fifo
    import systolic_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  feeder_word_t wdata,
    input  logic         pop,
    output feeder_word_t head,
    output logic         empty,
    output logic         full,
    output logic [1:0]   level
);

    feeder_word_t [FIFO_DEPTH-1:0] mem;
    feeder_word_t [FIFO_DEPTH-1:0] mem_nxt;
    logic [1:0] count;
    logic [1:0] wr_idx;

    // On a simultaneous pop the new word lands one slot lower, behind the survivors.
    always_comb begin
        mem_nxt = mem;
        wr_idx  = pop ? count - 2'd1 : count;
        if (pop) mem_nxt = mem >> $bits(feeder_word_t);
        if (push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_idx == 2'(i)) mem_nxt[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem   <= '0;
            count <= 2'd0;
        end else begin
            mem <= mem_nxt;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[0];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'(FIFO_DEPTH));
    assign level = count;

endmodule

// File: rtl/systolic_feeder.sv
// Column/row word-to-nibble serializer feeding a systolic tile in 4-cycle frames.
// FIFO depth per channel set by SYSTOLIC_FEEDER_FIFO2_EN (see systolic_pkg).
module systolic_feeder
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] col_data,
    input  logic [1:0]        col_addr,
    input  logic [1:0]        col_tag,
    input  logic              col_valid,
    output logic              col_ready,
    input  logic [WORD_W-1:0] row_data,
    input  logic [1:0]        row_addr,
    input  logic [1:0]        row_tag,
    input  logic              row_valid,
    output logic              row_ready,
    output logic [NIB_W-1:0]  col_nib,
    output logic              col_ctrl,
    output logic [NIB_W-1:0]  row_nib,
    output logic              row_ctrl,
    output logic [1:0]        phase,
    output logic              frame_start,
    output logic [1:0]        col_level,
    output logic [1:0]        row_level
);

    logic [1:0]   phase_nxt;
    logic         launch;
    feeder_word_t col_in, row_in;
    feeder_word_t col_head, row_head;
    feeder_word_t col_frame, row_frame;
    feeder_word_t col_frame_nxt, row_frame_nxt;
    logic         col_empty, row_empty, col_full, row_full;
    logic         col_push, row_push, col_pop, row_pop;

    assign phase_nxt = phase + 2'd1;
    assign launch    = (phase == 2'(NIBBLES - 1));

    assign col_in = '{data: col_data, addr: col_addr, tag: col_tag};
    assign row_in = '{data: row_data, addr: row_addr, tag: row_tag};

    assign col_ready = !col_full;
    assign row_ready = !row_full;
    assign col_push  = col_valid && col_ready;
    assign row_push  = row_valid && row_ready;
    // Launch reads only entries stored before this edge; a same-edge push waits a frame.
    assign col_pop   = launch && !col_empty;
    assign row_pop   = launch && !row_empty;

    feeder_fifo u_col_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (col_push),
        .wdata (col_in),
        .pop   (col_pop),
        .head  (col_head),
        .empty (col_empty),
        .full  (col_full),
        .level (col_level)
    );

    feeder_fifo u_row_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (row_push),
        .wdata (row_in),
        .pop   (row_pop),
        .head  (row_head),
        .empty (row_empty),
        .full  (row_full),
        .level (row_level)
    );

    always_comb begin
        col_frame_nxt = col_frame;
        row_frame_nxt = row_frame;
        if (launch) begin
            col_frame_nxt = col_empty ? IDLE_WORD : col_head;
            row_frame_nxt = row_empty ? IDLE_WORD : row_head;
        end
    end

    // Outputs are selected from next-cycle frame/phase so they land exactly on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= 2'd0;
            frame_start <= 1'b1;
            col_frame   <= IDLE_WORD;
            row_frame   <= IDLE_WORD;
            col_nib     <= '0;
            col_ctrl    <= 1'b0;
            row_nib     <= '0;
            row_ctrl    <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            frame_start <= (phase_nxt == 2'd0);
            col_frame   <= col_frame_nxt;
            row_frame   <= row_frame_nxt;
            col_nib     <= word_nib(col_frame_nxt, phase_nxt);
            col_ctrl    <= word_ctrl(col_frame_nxt, phase_nxt);
            row_nib     <= word_nib(row_frame_nxt, phase_nxt);
            row_ctrl    <= word_ctrl(row_frame_nxt, phase_nxt);
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: queue-based frame model compared every cycle,
// plus directed frames with literal expected nibbles. Honors SYSTOLIC_FEEDER_FIFO2_EN.
module tb_systolic_feeder;
    import systolic_pkg::*;

`ifdef SYSTOLIC_FEEDER_FIFO2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] col_data = '0, row_data = '0;
    logic [1:0]  col_addr = '0, col_tag = '0, row_addr = '0, row_tag = '0;
    logic        col_valid = 1'b0, row_valid = 1'b0;
    logic        col_ready, row_ready, col_ctrl, row_ctrl, frame_start;
    logic [3:0]  col_nib, row_nib;
    logic [1:0]  phase, col_level, row_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .col_data(col_data), .col_addr(col_addr), .col_tag(col_tag),
        .col_valid(col_valid), .col_ready(col_ready),
        .row_data(row_data), .row_addr(row_addr), .row_tag(row_tag),
        .row_valid(row_valid), .row_ready(row_ready),
        .col_nib(col_nib), .col_ctrl(col_ctrl), .row_nib(row_nib), .row_ctrl(row_ctrl),
        .phase(phase), .frame_start(frame_start),
        .col_level(col_level), .row_level(row_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    feeder_word_t mq_c[$], mq_r[$];
    logic [15:0]  mfr_c_d, mfr_r_d;
    logic [3:0]   mfr_c_k, mfr_r_k;
    int           mph = 0;
    bit           mon = 0;

    initial forever begin
        int sc, sr;
        @(posedge clk);
        if (!rst_n) begin
            mq_c.delete(); mq_r.delete();
            mph = 0; mfr_c_d = 0; mfr_c_k = 0; mfr_r_d = 0; mfr_r_k = 0;
            mon = 1;
        end else begin
            sc = mq_c.size();
            sr = mq_r.size();
            if (mph == 3) begin
                mfr_c_d = 0; mfr_c_k = 0; mfr_r_d = 0; mfr_r_k = 0;
                if (sc > 0) begin
                    feeder_word_t w;
                    w = mq_c.pop_front();
                    mfr_c_d = w.data; mfr_c_k = {w.addr, w.tag};
                end
                if (sr > 0) begin
                    feeder_word_t w;
                    w = mq_r.pop_front();
                    mfr_r_d = w.data; mfr_r_k = {w.addr, w.tag};
                end
            end
            if (col_valid && sc < D) mq_c.push_back('{col_data, col_addr, col_tag});
            if (row_valid && sr < D) mq_r.push_back('{row_data, row_addr, row_tag});
            mph = (mph + 1) % 4;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon) begin
            chk("phase", phase, mph);
            chk("frame_start", frame_start, (mph == 0));
            chk("col_nib", col_nib, (mfr_c_d >> (12 - 4 * mph)) & 16'hF);
            chk("col_ctrl", col_ctrl, (mfr_c_k >> (3 - mph)) & 4'h1);
            chk("row_nib", row_nib, (mfr_r_d >> (12 - 4 * mph)) & 16'hF);
            chk("row_ctrl", row_ctrl, (mfr_r_k >> (3 - mph)) & 4'h1);
            chk("col_ready", col_ready, (mq_c.size() < D));
            chk("row_ready", row_ready, (mq_r.size() < D));
            chk("col_level", col_level, mq_c.size());
            chk("row_level", row_level, mq_r.size());
        end
    end

    // ---------------- directed helpers (called at a negedge) ----------------
    task automatic wait_phase(input logic [1:0] p);
        int n = 0;
        while (phase !== p && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (phase !== p) chk("wait_phase_timeout", phase, p);
    endtask

    task automatic send_col(input logic [15:0] d, input logic [1:0] a, input logic [1:0] t);
        logic r;
        int n = 0;
        col_valid = 1'b1; col_data = d; col_addr = a; col_tag = t;
        do begin
            r = col_ready;
            @(negedge clk);
            n++;
        end while (!r && n < 40);
        if (!r) chk("send_col_timeout", 0, 1);
        col_valid = 1'b0;
    endtask

    task automatic send_row(input logic [15:0] d, input logic [1:0] a, input logic [1:0] t);
        logic r;
        int n = 0;
        row_valid = 1'b1; row_data = d; row_addr = a; row_tag = t;
        do begin
            r = row_ready;
            @(negedge clk);
            n++;
        end while (!r && n < 40);
        if (!r) chk("send_row_timeout", 0, 1);
        row_valid = 1'b0;
    endtask

    // Checks one whole frame from a phase-0 negedge against literal words.
    task automatic expect_frame(input string name, input logic [15:0] cd, input logic [3:0] cc,
                                input logic [15:0] rd, input logic [3:0] rc);
        for (int k = 0; k < 4; k++) begin
            chk({name, "_phase"}, phase, k);
            chk({name, "_col_nib"}, col_nib, (cd >> (12 - 4 * k)) & 16'hF);
            chk({name, "_col_ctrl"}, col_ctrl, (cc >> (3 - k)) & 4'h1);
            chk({name, "_row_nib"}, row_nib, (rd >> (12 - 4 * k)) & 16'hF);
            chk({name, "_row_ctrl"}, row_ctrl, (rc >> (3 - k)) & 4'h1);
            @(negedge clk);
        end
    endtask

    logic [15:0] wd [4];
    logic [3:0]  wc [4];
    int          nw;

    initial begin
        wd[0] = 16'hC0DE; wc[0] = 4'b0101;
        wd[1] = 16'h7E57; wc[1] = 4'b1010;
        wd[2] = 16'h0F0F; wc[2] = 4'b1111;
        wd[3] = 16'h8421; wc[3] = 4'b0001;
        nw = (D == 2) ? 4 : 2;

        // Test 1: reset for 3 cycles, then free-running idle frames.
        repeat (3) @(negedge clk);
        chk("t1_rst_phase", phase, 0);
        chk("t1_rst_frame_start", frame_start, 1);
        chk("t1_rst_col_nib", col_nib, 0);
        chk("t1_rst_row_nib", row_nib, 0);
        chk("t1_rst_col_ready", col_ready, 1);
        chk("t1_rst_row_ready", row_ready, 1);
        rst_n = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("t1_phase", phase, k);
            chk("t1_col_nib", col_nib, 0);
            chk("t1_col_ctrl", col_ctrl, 0);
            chk("t1_row_ctrl", row_ctrl, 0);
        end

        // Test 2: one column word pushed at phase 1 emerges in the next frame.
        wait_phase(2'd1);
        col_valid = 1'b1; col_data = 16'hABCD; col_addr = 2'd1; col_tag = 2'd2;
        @(negedge clk);
        col_valid = 1'b0;
        wait_phase(2'd0);
        expect_frame("t2", 16'hABCD, 4'b0110, 16'h0000, 4'b0000);

        // Test 3: words pushed on the launch edge skip that launch.
        wait_phase(2'd3);
        col_valid = 1'b1; col_data = 16'h1234; col_addr = 2'd2; col_tag = 2'd0;
        row_valid = 1'b1; row_data = 16'h5678; row_addr = 2'd3; row_tag = 2'd0;
        @(negedge clk);
        col_valid = 1'b0; row_valid = 1'b0;
        expect_frame("t3_idle", 16'h0000, 4'b0000, 16'h0000, 4'b0000);
        expect_frame("t3_launch", 16'h1234, 4'b1000, 16'h5678, 4'b1100);

        // Test 4/5: sustained column valid; ready drops at full, frames stay back-to-back.
        wait_phase(2'd0);
        fork
            begin
                for (int i = 0; i < nw; i++) send_col(wd[i], wc[i][3:2], wc[i][1:0]);
            end
            begin
                wait_phase(2'd2);
                chk("t45_full_ready", col_ready, 0);
                chk("t45_full_level", col_level, D);
                wait_phase(2'd0);
                for (int i = 0; i < nw; i++) expect_frame("t45_stream", wd[i], wc[i], 16'h0, 4'h0);
            end
        join

        // Mixed traffic on both channels, checked by the model only.
        fork
            begin
                send_col(16'h1111, 2'd1, 2'd0);
                send_col(16'h2222, 2'd2, 2'd1);
                send_col(16'h3333, 2'd3, 2'd3);
            end
            begin
                send_row(16'h9ABC, 2'd1, 2'd1);
                repeat (3) @(negedge clk);
                send_row(16'hDEF0, 2'd2, 2'd2);
            end
        join
        repeat (20) @(negedge clk);

        // Test 6: reset mid-frame with a queued word.
        wait_phase(2'd1);
        col_valid = 1'b1; col_data = 16'hBEEF; col_addr = 2'd1; col_tag = 2'd3;
        @(negedge clk);
        col_valid = 1'b0;
        chk("t6_queued_level", col_level, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_phase", phase, 0);
        chk("t6_col_nib", col_nib, 0);
        chk("t6_col_ctrl", col_ctrl, 0);
        chk("t6_col_level", col_level, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_flushed_nib", col_nib, 0);
            chk("t6_flushed_ctrl", col_ctrl, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Word-to-stream serializer that sits directly upstream of a systolic tile and drives its column and row input ports. It accepts independent 16-bit column and row words, each with a 2-bit address and 2-bit tag, over valid/ready handshakes. It emits them nibble-serially, MSB nibble first, with a 1-bit-per-cycle control stream, in 4-cycle frames aligned to the tile's block counter. When a channel has no queued word, that channel sends an idle "pass" frame.

## Interface
- Parameters: none (widths are fixed by `systolic_pkg`).
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `col_data` input 16: column word; `[15:8]` is element 0 and `[7:0]` is element 1, or a full C value.
- `col_addr` input 2: column frame address. 0 = pass, 1 = A, 2 = C0, 3 = C2.
- `col_tag` input 2: low control bits, carried through the tile unchanged.
- `col_valid` input 1 / `col_ready` output 1: column handshake.
- `row_data`, `row_addr`, `row_tag`, `row_valid` inputs / `row_ready` output: row channel, same layout. Row addresses: 1 = B, 2 = C1, 3 = C3.
- `col_nib` output 4: column data nibble, connects to the tile's column nibble input.
- `col_ctrl` output 1: column control bit.
- `row_nib` output 4: row data nibble.
- `row_ctrl` output 1: row control bit.
- `phase` output 2: current frame phase; equals the tile's block counter.
- `frame_start` output 1: high when `phase==0`.
- `col_level` output 2, `row_level` output 2: FIFO occupancy.

## Operation
- Control word is `ctrl[3:0] = {addr, tag}`. An idle frame is data 0x0000 with ctrl 4'b0000.
- `phase` is a free-running 2-bit counter: reset to 0, +1 every cycle, wraps 3→0.
- Each channel has a FIFO of depth D (see Configuration).
  - `*_ready` = FIFO not full.
  - A push occurs on a posedge with `valid && ready`.
- Launch happens at a posedge where `phase==3`. Each channel independently does one of:
  - FIFO non-empty: pop the head into that channel's 20-bit frame register.
  - FIFO empty: load the idle frame.
- Push and pop in the same edge are legal. Occupancy then stays the same, and order is preserved.
- A word pushed on the launch edge itself is not eligible for that launch. Launch reads only previously stored entries.
- Frame register output, while `phase==k`:
  - `*_nib` = `data[15-4k : 12-4k]`.
  - `*_ctrl` = `ctrl[3-k]`.
- Outputs are registered. Frame register plus a phase-indexed mux are computed one cycle ahead, so the outputs change only at posedge.
- Column and row channels never stall each other. A frame pairs whatever each FIFO holds at the launch edge.
- Reset values:
  - `phase`=0; `frame_start`=1.
  - `*_nib`=0 and `*_ctrl`=0, i.e. an idle frame is in progress.
  - FIFOs empty; `*_level`=0.
  - `*_ready`=1 from the first cycle after reset.
- Reset mid-frame: the partial frame is abandoned, FIFOs are flushed, and outputs go to 0 on the reset edge. The tile is reset by the same `rst_n`, so both counters restart together.

## Timing
- Latency:
  - Word accepted at posedge E: its nibble 0 appears in the cycle after the first `phase==3` edge strictly after E.
  - Best case 1 cycle (accepted at the `phase==2` edge).
  - Worst case 4 cycles (accepted at the `phase==3` edge), assuming the FIFO was empty.
- Throughput: one word per channel per 4 cycles. Sustained `valid` fills the FIFO and `ready` then toggles.
- `*_ready` is a function of registered occupancy only; there is no combinational path from `valid` to `ready`.
- Full FIFO at a launch edge: a pop occurs, but `ready` was already low, so no push is possible that edge.

## Configuration
- `SYSTOLIC_FEEDER_FIFO2_EN`:
  - Defined: D=2 per channel; `*_level` ranges 0..2. Back-to-back frames are sustainable with `valid` arriving anywhere in the prior frame.
  - Undefined: D=1 (a single holding register); `*_level` ranges 0..1, bit 1 tied to 0. Sustained streaming requires the next push to land after the previous launch edge.

## Structure
- `systolic_pkg` holds:
  - `WORD_W=16`, `NIB_W=4`, `NIBBLES=4`.
  - Address constants `ADDR_PASS=2'd0`, `ADDR_AB=2'd1`, `ADDR_CLO=2'd2`, `ADDR_CHI=2'd3`.
  - Typedef `feeder_word_t` = struct `{data[15:0], addr[1:0], tag[1:0]}`.
  - `IDLE_WORD` constant.
- Sub-module `feeder_fifo`: one per channel (two instances).
  - Holds `feeder_word_t` entries, depth set by the macro.
  - Provides push/pop/level signals.
  - Phase counter and serializer stay in the top module.

## Test plan
1. Reset held 3 cycles, then released, no valid → `phase` cycles 0,1,2,3; `*_nib`=0 and `*_ctrl`=0 every cycle; `*_ready`=1.
2. Push col 0xABCD, addr 1, tag 2 at the `phase==1` edge → in the next frame, `col_nib`=A,B,C,D and `col_ctrl`=0,1,1,0 over phases 0..3. The row channel stays idle (zeros).
3. Push col 0x1234/addr 2 and row 0x5678/addr 3 on the same `phase==3` edge → not launched in the following frame (idle frame sent). Launched in the frame after that: col nibbles 1,2,3,4, col ctrl 1,0,0,0; row nibbles 5,6,7,8, row ctrl 1,1,0,0.
4. With FIFO2_EN, hold col_valid high with words W0..W3 → `col_ready` drops when `col_level`=2. Frames carry W0..W3 back-to-back with no idle gap and no loss or reordering.
5. Without FIFO2_EN, push two words in one frame → second push stalls (`col_ready`=0) until the launch edge. Words emit in consecutive frames.
6. Assert `rst_n`=0 at `phase==2` mid-frame with a queued word → next cycle shows outputs 0, `phase`=0, `col_level`=0. The queued word is never emitted.
